// File: rtl/uart_block_assembler.sv
// Packs a UART byte stream into BLOCK_BYTES-wide blocks with a one-deep output holding register.
// Optional inter-byte timeout is built only when IDH_TIMEOUT_EN is defined.
module uart_block_assembler #(
    parameter int BLOCK_BYTES = 64,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int TIMEOUT_CYC = 100000,
    localparam int CW = $clog2(BLOCK_BYTES + 1),
    localparam int DW = 8 * BLOCK_BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    input  logic          flush,
    input  logic          idh_ready,
    output logic [DW-1:0] d_out,
    output logic          idh_dv,
    output logic [CW-1:0] byte_cnt,
    output logic [15:0]   blk_cnt,
    output logic          ovf_err,
    output logic          to_err
);

    typedef enum logic [0:0] {LOAD = 1'b0, XFER = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] asm_q, asm_d;
    logic [DW-1:0] d_out_q, d_out_d;
    logic          idh_dv_q, idh_dv_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [15:0]   blk_cnt_q, blk_cnt_d;
    logic          ovf_q, ovf_d;
    logic          to_q, to_d;
`ifdef IDH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_q, idle_d;
`endif

    // Byte k lands at the top of the block when MSB_FIRST, else at the bottom.
    function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] buf_v,
                                               input logic [CW-1:0] idx,
                                               input logic [7:0]    b);
        logic [DW-1:0] r;
        r = buf_v;
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (idx == CW'(k)) begin
                if (MSB_FIRST) begin
                    r[8*(BLOCK_BYTES-1-k) +: 8] = b;
                end else begin
                    r[8*k +: 8] = b;
                end
            end
        end
        return r;
    endfunction

    // Next-state logic for assembly, hand-off and error pulses.
    always_comb begin
        state_d    = state_q;
        asm_d      = asm_q;
        d_out_d    = d_out_q;
        idh_dv_d   = idh_dv_q;
        byte_cnt_d = byte_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        ovf_d      = 1'b0;
        to_d       = 1'b0;
`ifdef IDH_TIMEOUT_EN
        idle_d     = '0;
`endif
        if (idh_dv_q && idh_ready) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
            idh_dv_d  = 1'b0;
        end else begin
            blk_cnt_d = blk_cnt_q;
        end

        case (state_q)
            LOAD: begin
                if (flush) begin
                    byte_cnt_d = '0;
                end else if (byte_valid) begin
                    asm_d      = put_byte(asm_q, byte_cnt_q, byte_data);
                    byte_cnt_d = byte_cnt_q + CW'(1);
                    if (byte_cnt_q == CW'(BLOCK_BYTES - 1)) begin
                        state_d = XFER;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
`ifdef IDH_TIMEOUT_EN
                    if (byte_cnt_q != '0) begin
                        if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
                            byte_cnt_d = '0;
                            to_d       = 1'b1;
                            idle_d     = '0;
                        end else begin
                            idle_d = idle_q + TW'(1);
                        end
                    end else begin
                        idle_d = '0;
                    end
`else
                    byte_cnt_d = byte_cnt_q;
`endif
                end
            end
            XFER: begin
                // Output register is free or being popped this edge: move the block out.
                if (!idh_dv_q || idh_ready) begin
                    d_out_d  = asm_q;
                    idh_dv_d = 1'b1;
                    state_d  = LOAD;
                    if (byte_valid) begin
                        asm_d      = put_byte(asm_q, '0, byte_data);
                        byte_cnt_d = CW'(1);
                    end else begin
                        byte_cnt_d = '0;
                    end
                end else begin
                    ovf_d = byte_valid;
                end
            end
            default: begin
                state_d    = LOAD;
                byte_cnt_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            asm_q      <= '0;
            d_out_q    <= '0;
            idh_dv_q   <= 1'b0;
            byte_cnt_q <= '0;
            blk_cnt_q  <= 16'd0;
            ovf_q      <= 1'b0;
            to_q       <= 1'b0;
`ifdef IDH_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            d_out_q    <= d_out_d;
            idh_dv_q   <= idh_dv_d;
            byte_cnt_q <= byte_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            ovf_q      <= ovf_d;
            to_q       <= to_d;
`ifdef IDH_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign d_out    = d_out_q;
    assign idh_dv   = idh_dv_q;
    assign byte_cnt = byte_cnt_q;
    assign blk_cnt  = blk_cnt_q;
    assign ovf_err  = ovf_q;
    assign to_err   = to_q;

endmodule
